// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                    |
// | Description : RV32I memory-access / writeback stage with word data RAM,   |
// |               byte/half/word sizing and a counted multi-cycle load wait.   |
// |               Optional macro MEM_MISALIGN_TRAP_EN adds misalignment trap.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage #(
    parameter int DEPTH    = 256,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        mem_misalign
`endif
);

    localparam int         c_AW     = $clog2(DEPTH);
    localparam bit         c_MULTI  = (LOAD_LAT > 1);
    localparam logic [3:0] c_LAT_M1 = 4'(LOAD_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_fire_pend;

    logic [31:0] r_mem [DEPTH];

    logic            w_accept;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_start_wait;
    logic            w_fire_direct;
    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic [1:0]      w_size;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_we;
    logic            w_mis;
    logic [31:0]     w_rword;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ld;
    logic [31:0]     w_wb_data;
    logic            w_wb_we;

    logic [31:0]     r_p_data;
    logic [4:0]      r_p_rd;
    logic            r_p_we;

    logic            w_unused_addr;
    assign w_unused_addr = &{1'b0, ex_result[31:c_AW+2]};

    assign ex_ready     = (r_state == S_IDLE);
    assign w_accept     = ex_valid & ex_ready;
    // A simultaneous read+write is a load, never a store.
    assign w_is_load    = ex_mem_read;
    assign w_is_store   = ex_mem_write & ~ex_mem_read;
    assign w_start_wait = w_accept & w_is_load & c_MULTI;
    assign w_fire_direct = w_accept & ~w_start_wait;
    assign w_idx        = ex_result[c_AW+1:2];
    assign w_lane       = ex_result[1:0];

    // Access size: 0 byte, 1 half, 2 word; load and store decode differ at 100.
    always_comb begin
        w_size = 2'd2;
        if (ex_mem_read) begin
            case (ex_funct3)
                3'b000, 3'b100: w_size = 2'd0;
                3'b001, 3'b101: w_size = 2'd1;
                default:        w_size = 2'd2;
            endcase
        end else begin
            case (ex_funct3)
                3'b000:  w_size = 2'd0;
                3'b001:  w_size = 2'd1;
                default: w_size = 2'd2;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = (ex_mem_read | ex_mem_write) &
                   (((w_size == 2'd1) & ex_result[0]) |
                    ((w_size == 2'd2) & (ex_result[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = ex_store_data;
        case (w_size)
            2'd0: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'd1: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    assign w_we = w_accept & w_is_store & ~w_mis & ~reset;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        case (ex_funct3)
            3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld = {24'h0, w_byte};
            3'b101:  w_ld = {16'h0, w_half};
            default: w_ld = w_rword;
        endcase
    end

    assign w_wb_data = w_is_load ? w_ld : ex_result;
    assign w_wb_we   = ex_reg_write & (ex_rd != 5'd0) & ~w_is_store & ~w_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire_pend = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_wait) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_LAT_M1;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_fire_pend = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Load result is captured at acceptance so later stores cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            r_p_data     <= 32'd0;
            r_p_rd       <= 5'd0;
            r_p_we       <= 1'b0;
        end else begin
            wb_valid <= w_fire_direct | w_fire_pend;
            if (w_fire_direct) begin
                wb_reg_write <= w_wb_we;
                wb_rd        <= ex_rd;
                wb_data      <= w_wb_data;
            end else if (w_fire_pend) begin
                wb_reg_write <= r_p_we;
                wb_rd        <= r_p_rd;
                wb_data      <= r_p_data;
            end
            if (w_start_wait) begin
                r_p_data <= w_wb_data;
                r_p_rd   <= ex_rd;
                r_p_we   <= w_wb_we;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_p_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_misalign <= 1'b0;
            r_p_mis      <= 1'b0;
        end else begin
            if (w_fire_direct)    mem_misalign <= w_mis;
            else if (w_fire_pend) mem_misalign <= r_p_mis;
            else                  mem_misalign <= 1'b0;
            if (w_start_wait) r_p_mis <= w_mis;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                 |
// | Description : Directed self-checking bench for mem_stage (LOAD_LAT 2 and 4)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, reset4;
    logic        ex_valid, ex_valid4;
    logic        ex_ready, ex_ready4;
    logic [31:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        wb_valid, wb_reg_write, wb_valid4, wb_reg_write4;
    logic [4:0]  wb_rd, wb_rd4;
    logic [31:0] wb_data, wb_data4;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_misalign, mem_misalign4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(256), .LOAD_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .mem_misalign(mem_misalign)
`endif
    );

    mem_stage #(.DEPTH(256), .LOAD_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset4), .ex_valid(ex_valid4), .ex_ready(ex_ready4),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .wb_valid(wb_valid4), .wb_reg_write(wb_reg_write4), .wb_rd(wb_rd4),
        .wb_data(wb_data4)
`ifdef MEM_MISALIGN_TRAP_EN
        , .mem_misalign(mem_misalign4)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_funct3     = f3;
        ex_result     = addr;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_valid      = 1'b1;
    endtask

    // Issues a LOAD_LAT=2 load on u_dut and stops once its writeback is visible.
    task automatic issue_load(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [4:0] rd);
        drive(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; reset4 = 1'b1;
        repeat (2) step();
        reset = 1'b0; reset4 = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_wb_reg_write got %0b want 0", wb_reg_write); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %0b want 1", ex_ready); end
        checks++; if (ex_ready4 !== 1'b1) begin errors++; $display("FAIL reset_ex_ready4 got %0b want 1", ex_ready4); end
    endtask

    task automatic test_nonmem();
        drive(1'b0, 1'b0, 3'b000, 32'h0000_00AB, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid got %0b want 1", wb_valid); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL nonmem_rd got %0d want 5", wb_rd); end
        checks++; if (wb_data !== 32'h0000_00AB) begin errors++; $display("FAIL nonmem_data got %h want 000000ab", wb_data); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL nonmem_we got %0b want 1", wb_reg_write); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL nonmem_ready got %0b want 1", ex_ready); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", wb_valid); end
        checks++; if (wb_data !== 32'h0000_00AB) begin errors++; $display("FAIL idle_hold_data got %h want 000000ab", wb_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'b000, vals[i], 32'h0, 5'(10 + i), 1'b1);
            step();
            checks++; if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_rd !== 5'(10 + i))
                begin errors++; $display("FAIL b2b_%0d got v=%0b d=%h rd=%0d want v=1 d=%h rd=%0d", i, wb_valid, wb_data, wb_rd, vals[i], 10 + i); end
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0044, 32'h0, 5'd0, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            begin errors++; $display("FAIL nonmem_rd0 got v=%0b we=%0b want v=1 we=0", wb_valid, wb_reg_write); end
        step();
    endtask

    task automatic test_load_sizes();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [31:0] adrs [6] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10, 32'h10};
        logic [31:0] exps [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000,
                                  32'h0000_8000, 32'h8000_00F0, 32'h8000_00F0};
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h8000_00F0, 5'd7, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || ex_ready !== 1'b1)
            begin errors++; $display("FAIL sw_wb got v=%0b we=%0b rdy=%0b want v=1 we=0 rdy=1", wb_valid, wb_reg_write, ex_ready); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 5'(3 + i), 1'b1);
            step();
            ex_valid = 1'b0;
            checks++; if (ex_ready !== 1'b0 || wb_valid !== 1'b0)
                begin errors++; $display("FAIL load%0d_wait got rdy=%0b v=%0b want rdy=0 v=0", i, ex_ready, wb_valid); end
            step();
            checks++; if (ex_ready !== 1'b1 || wb_valid !== 1'b1)
                begin errors++; $display("FAIL load%0d_done got rdy=%0b v=%0b want rdy=1 v=1", i, ex_ready, wb_valid); end
            checks++; if (wb_data !== exps[i] || wb_rd !== 5'(3 + i) || wb_reg_write !== 1'b1)
                begin errors++; $display("FAIL load%0d_data got d=%h rd=%0d we=%0b want d=%h rd=%0d we=1", i, wb_data, wb_rd, wb_reg_write, exps[i], 3 + i); end
            step();
            checks++; if (wb_valid !== 1'b0)
                begin errors++; $display("FAIL load%0d_pulse got v=%0b want 0", i, wb_valid); end
        end
    endtask

    task automatic test_store_bytes();
        drive(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 5'd1, 1'b1);
        step();
        drive(1'b0, 1'b1, 3'b000, 32'h21, 32'hAAAA_AA55, 5'd9, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            begin errors++; $display("FAIL sb_wb got v=%0b we=%0b want v=1 we=0", wb_valid, wb_reg_write); end
        issue_load(3'b010, 32'h20, 5'd2);
        checks++; if (wb_data !== 32'h0000_5500) begin errors++; $display("FAIL sb_lw got %h want 00005500", wb_data); end
        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        issue_load(3'b010, 32'h20, 5'd2);
        checks++; if (wb_data !== 32'hBEEF_5500) begin errors++; $display("FAIL sh_lw got %h want beef5500", wb_data); end
        // Both read and write asserted behaves as a load and leaves RAM alone.
        drive(1'b1, 1'b1, 3'b010, 32'h20, 32'hDEAD_DEAD, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hBEEF_5500 || wb_reg_write !== 1'b1)
            begin errors++; $display("FAIL rw_as_load got v=%0b d=%h we=%0b want v=1 d=beef5500 we=1", wb_valid, wb_data, wb_reg_write); end
        issue_load(3'b010, 32'h20, 5'd4);
        checks++; if (wb_data !== 32'hBEEF_5500) begin errors++; $display("FAIL rw_no_write got %h want beef5500", wb_data); end
    endtask

    task automatic test_rd0_and_wrap();
        issue_load(3'b010, 32'h20, 5'd0);
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            begin errors++; $display("FAIL load_rd0 got v=%0b we=%0b want v=1 we=0", wb_valid, wb_reg_write); end
        drive(1'b0, 1'b1, 3'b010, 32'd1032, 32'h1234_5678, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        issue_load(3'b010, 32'h8, 5'd8);
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL wrap got %h want 12345678", wb_data); end
`ifndef MEM_MISALIGN_TRAP_EN
        issue_load(3'b010, 32'h13, 5'd8);
        checks++; if (wb_data !== 32'h8000_00F0) begin errors++; $display("FAIL align_lw got %h want 800000f0", wb_data); end
        issue_load(3'b001, 32'h11, 5'd8);
        checks++; if (wb_data !== 32'h0000_00F0) begin errors++; $display("FAIL align_lh got %h want 000000f0", wb_data); end
`endif
        step();
    endtask

    task automatic test_lat4_abort();
        drive(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 5'd0, 1'b0);
        ex_valid = 1'b0; ex_valid4 = 1'b1;
        step();
        ex_valid4 = 1'b0;
        checks++; if (wb_valid4 !== 1'b1) begin errors++; $display("FAIL l4_sw got v=%0b want 1", wb_valid4); end
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd6, 1'b1);
        ex_valid = 1'b0; ex_valid4 = 1'b1;
        step();
        ex_valid4 = 1'b0;
        step();
        checks++; if (ex_ready4 !== 1'b0) begin errors++; $display("FAIL l4_wait got rdy=%0b want 0", ex_ready4); end
        reset4 = 1'b1;
        step();
        reset4 = 1'b0;
        checks++; if (wb_valid4 !== 1'b0 || ex_ready4 !== 1'b1 || wb_data4 !== 32'h0 || wb_rd4 !== 5'd0 || wb_reg_write4 !== 1'b0)
            begin errors++; $display("FAIL l4_reset got v=%0b rdy=%0b d=%h rd=%0d we=%0b want 0 1 0 0 0", wb_valid4, ex_ready4, wb_data4, wb_rd4, wb_reg_write4); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (wb_valid4 !== 1'b0) begin errors++; $display("FAIL l4_abort_%0d got v=%0b want 0", k, wb_valid4); end
        end
        ex_valid4 = 1'b1;
        step();
        ex_valid4 = 1'b0;
        for (int k = 1; k < 3; k++) begin
            step();
            checks++; if (ex_ready4 !== 1'b0 || wb_valid4 !== 1'b0)
                begin errors++; $display("FAIL l4_lat_%0d got rdy=%0b v=%0b want 0 0", k, ex_ready4, wb_valid4); end
        end
        step();
        checks++; if (wb_valid4 !== 1'b1 || ex_ready4 !== 1'b1 || wb_data4 !== 32'hCAFE_F00D || wb_rd4 !== 5'd6)
            begin errors++; $display("FAIL l4_load got v=%0b rdy=%0b d=%h rd=%0d want 1 1 cafef00d 6", wb_valid4, ex_ready4, wb_data4, wb_rd4); end
        step();
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        drive(1'b0, 1'b1, 3'b010, 32'h30, 32'h1111_1111, 5'd0, 1'b0);
        step();
        checks++; if (mem_misalign !== 1'b0) begin errors++; $display("FAIL mis_aligned got %0b want 0", mem_misalign); end
        drive(1'b0, 1'b1, 3'b010, 32'h31, 32'h2222_2222, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        checks++; if (mem_misalign !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            begin errors++; $display("FAIL mis_sw got mis=%0b v=%0b we=%0b want 1 1 0", mem_misalign, wb_valid, wb_reg_write); end
        step();
        checks++; if (mem_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse got %0b want 0", mem_misalign); end
        issue_load(3'b010, 32'h30, 5'd3);
        checks++; if (wb_data !== 32'h1111_1111 || mem_misalign !== 1'b0)
            begin errors++; $display("FAIL mis_lw got d=%h mis=%0b want 11111111 0", wb_data, mem_misalign); end
        issue_load(3'b010, 32'h32, 5'd3);
        checks++; if (mem_misalign !== 1'b1 || wb_reg_write !== 1'b0 || wb_valid !== 1'b1)
            begin errors++; $display("FAIL mis_lw_trap got mis=%0b we=%0b v=%0b want 1 0 1", mem_misalign, wb_reg_write, wb_valid); end
        step();
    endtask
`endif

    initial begin
        reset = 1'b1; reset4 = 1'b1;
        ex_valid = 1'b0; ex_valid4 = 1'b0;
        ex_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'b000;
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_load_sizes();
        test_store_bytes();
        test_rd0_and_wrap();
        test_lat4_abort();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
